// File: rtl/mem_line_master.sv
// Initiator for the 128-bit line-transfer handshake to slow memory:
// optional dirty-line write-back followed by optional refill, one transaction at a time.
module mem_line_master #(
  parameter int unsigned ADDR_W  = 28,
  parameter int unsigned LINE_W  = 128,
  parameter int unsigned TIMEOUT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wb,
  input  logic [ADDR_W-1:0] req_wb_addr,
  input  logic [LINE_W-1:0] req_wb_data,
  input  logic              req_fill,
  input  logic [ADDR_W-1:0] req_fill_addr,
  output logic              resp_valid,
  output logic [LINE_W-1:0] resp_data,
  output logic              resp_err,
  output logic              busy,
  output logic [15:0]       fill_cnt,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  localparam int unsigned CNT_W  = 32;
  localparam int unsigned FCNT_W = 16;

  typedef enum logic [2:0] {IDLE, WB_REQ, GAP, RD_REQ, RESP} state_t;

  state_t              state, state_n;
  logic                fill_q, fill_n;
  logic [ADDR_W-1:0]   fill_addr_q, fill_addr_n;
  logic [CNT_W-1:0]    tmo_cnt, tmo_cnt_n;
  logic                tmo_hit;

  logic                mem_read_n, mem_write_n, busy_n, resp_valid_n, resp_err_n;
  logic [ADDR_W-1:0]   mem_addr_n;
  logic [LINE_W-1:0]   mem_wdata_n, resp_data_n;
  logic [FCNT_W-1:0]   fill_cnt_n;

  assign req_ready = (state == IDLE);

  // A phase expires after TIMEOUT unanswered cycles; a same-edge mem_ready takes priority.
  assign tmo_hit = (TIMEOUT != 0) && !mem_ready && (tmo_cnt == CNT_W'(TIMEOUT - 1));

  // Next-state and next-output logic.
  always_comb begin
    state_n     = state;
    fill_n      = fill_q;
    fill_addr_n = fill_addr_q;
    mem_addr_n  = mem_addr;
    mem_wdata_n = mem_wdata;
    resp_data_n = resp_data;
    resp_err_n  = resp_err;
    fill_cnt_n  = fill_cnt;

    case (state)
      IDLE: begin
        if (req_valid) begin
          fill_n      = req_fill;
          fill_addr_n = req_fill_addr;
          resp_err_n  = 1'b0;
          if (req_wb) begin
            state_n     = WB_REQ;
            mem_addr_n  = req_wb_addr;
            mem_wdata_n = req_wb_data;
          end else if (req_fill) begin
            state_n    = RD_REQ;
            mem_addr_n = req_fill_addr;
          end else begin
            state_n = RESP;
          end
        end
      end
      WB_REQ: begin
        if (mem_ready) begin
          state_n = fill_q ? GAP : RESP;
        end else if (tmo_hit) begin
          state_n    = RESP;
          resp_err_n = 1'b1;
        end
      end
      GAP: begin
        state_n    = RD_REQ;
        mem_addr_n = fill_addr_q;
      end
      RD_REQ: begin
        if (mem_ready) begin
          state_n     = RESP;
          resp_data_n = mem_rdata;
          if (fill_cnt != {FCNT_W{1'b1}}) fill_cnt_n = fill_cnt + FCNT_W'(1);
        end else if (tmo_hit) begin
          state_n    = RESP;
          resp_err_n = 1'b1;
        end
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

    // Phase counter restarts whenever a request phase is (re)entered.
    if ((state == WB_REQ || state == RD_REQ) && state_n == state) tmo_cnt_n = tmo_cnt + CNT_W'(1);
    else tmo_cnt_n = '0;

    mem_write_n  = (state_n == WB_REQ);
    mem_read_n   = (state_n == RD_REQ);
    busy_n       = (state_n != IDLE);
    resp_valid_n = (state_n == RESP);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      fill_q      <= 1'b0;
      fill_addr_q <= '0;
      tmo_cnt     <= '0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      resp_valid  <= 1'b0;
      resp_data   <= '0;
      resp_err    <= 1'b0;
      fill_cnt    <= '0;
      busy        <= 1'b0;
    end else begin
      state       <= state_n;
      fill_q      <= fill_n;
      fill_addr_q <= fill_addr_n;
      tmo_cnt     <= tmo_cnt_n;
      mem_read    <= mem_read_n;
      mem_write   <= mem_write_n;
      mem_addr    <= mem_addr_n;
      mem_wdata   <= mem_wdata_n;
      resp_valid  <= resp_valid_n;
      resp_data   <= resp_data_n;
      resp_err    <= resp_err_n;
      fill_cnt    <= fill_cnt_n;
      busy        <= busy_n;
    end
  end

endmodule

// File: tb/tb_mem_line_master.sv
// Scoreboard bench for mem_line_master: transaction-level model, reactive memory, decoupled monitor.
module tb_mem_line_master;

  localparam int TMO   = 12;
  localparam int NEVER = 1000;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid, req_ready, req_wb, req_fill;
  logic [27:0]  req_wb_addr, req_fill_addr;
  logic [127:0] req_wb_data;
  logic         resp_valid, resp_err, busy;
  logic [127:0] resp_data;
  logic [15:0]  fill_cnt;
  logic         mem_read, mem_write, mem_ready;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata, mem_rdata;

  mem_line_master #(.ADDR_W(28), .LINE_W(128), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_wb(req_wb), .req_wb_addr(req_wb_addr), .req_wb_data(req_wb_data),
    .req_fill(req_fill), .req_fill_addr(req_fill_addr),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
    .busy(busy), .fill_cnt(fill_cnt),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit           wr;
    logic [27:0]  addr;
    logic [127:0] wdata;
    logic [127:0] rdata;
    int           delay;
    bit           gap;
  } op_t;

  typedef struct {
    logic [127:0] data;
    bit           err;
    logic [15:0]  cnt;
    bit           phase;
  } rsp_t;

  op_t  op_q[$];
  rsp_t exp_q[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_end = 0;

  logic [127:0] m_data = '0;
  logic [15:0]  m_cnt  = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Reactive memory: answers each request after its planned delay and audits the request.
  initial begin : memory
    op_t cur;
    bit  tracking = 0;
    bit  req;
    int  cnt = 0;
    int  idle = 100;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk); #1;
      mem_ready = 1'b0;
      mem_rdata = rnd128();
      if (rst) begin
        tracking = 0;
        continue;
      end
      req = mem_read || mem_write;
      if (req && !tracking) begin
        if (op_q.size() == 0) begin
          chk("unexpected_req", 128'(req), 128'(0));
        end else begin
          cur = op_q.pop_front();
          chk("req_kind", 128'(mem_write), 128'(cur.wr));
          if (cur.gap) chk("gap_len", 128'(idle), 128'(1));
          else         chk("no_b2b", 128'(idle >= 1), 128'(1));
          tracking = 1;
          cnt = 0;
        end
      end
      if (req && tracking) begin
        cnt++;
        chk("req_addr", 128'(mem_addr), 128'(cur.addr));
        if (cur.wr) chk("req_wdata", mem_wdata, cur.wdata);
        if (cnt == cur.delay) begin
          mem_ready = 1'b1;
          mem_rdata = cur.rdata;
          tracking  = 0;
          last_end  = cyc;
        end
      end else if (!req && tracking) begin
        chk("tmo_len", 128'(cnt), 128'(TMO));
        tracking = 0;
        last_end = cyc - 1;
      end else if (!req && $urandom_range(3) == 0) begin
        mem_ready = 1'b1;
      end
      idle = req ? 0 : idle + 1;
    end
  end

  // Response monitor and handshake-timing checks.
  initial begin : monitor
    rsp_t e;
    bit outstanding = 0;
    bit after_resp  = 0;
    forever begin
      @(negedge clk); #2;
      if (rst) begin
        outstanding = 0;
        after_resp  = 0;
        continue;
      end
      chk("rw_exclusive", 128'(mem_read && mem_write), 128'(0));
      chk("busy", 128'(busy), 128'(outstanding));
      if (resp_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_resp", 128'(resp_valid), 128'(0));
        end else begin
          e = exp_q.pop_front();
          chk("resp_data", resp_data, e.data);
          chk("resp_err", 128'(resp_err), 128'(e.err));
          chk("fill_cnt", 128'(fill_cnt), 128'(e.cnt));
          if (e.phase) chk("resp_latency", 128'(cyc), 128'(last_end + 1));
        end
        outstanding = 0;
        after_resp  = 1;
      end else begin
        if (after_resp)       chk("ready_after_resp", 128'(req_ready), 128'(1));
        else if (outstanding) chk("ready_while_busy", 128'(req_ready), 128'(0));
        after_resp = 0;
      end
      if (req_valid && req_ready) outstanding = 1;
    end
  end

  task automatic scramble(input bit hold);
    req_valid     = hold ? 1'b1 : 1'($urandom_range(1));
    req_wb        = 1'($urandom_range(1));
    req_fill      = 1'($urandom_range(1));
    req_wb_addr   = 28'($urandom());
    req_fill_addr = 28'($urandom());
    req_wb_data   = rnd128();
  endtask

  // Model the transaction, then present it once the block is ready. Called at a falling edge.
  task automatic issue(input bit wb, input bit fill, input logic [27:0] wa, input logic [127:0] wd,
                       input logic [27:0] fa, input int dwb, input int dfill,
                       input logic [127:0] rd, input bit hold);
    op_t  o;
    rsp_t r;
    bit   err = 0;
    int   n = 0;
    if (wb) begin
      o = '{wr: 1'b1, addr: wa, wdata: wd, rdata: '0, delay: dwb, gap: 1'b0};
      op_q.push_back(o);
      if (dwb > TMO) err = 1;
    end
    if (fill && !err) begin
      o = '{wr: 1'b0, addr: fa, wdata: '0, rdata: rd, delay: dfill, gap: wb};
      op_q.push_back(o);
      if (dfill > TMO) err = 1;
      else begin
        m_data = rd;
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      end
    end
    r = '{data: m_data, err: err, cnt: m_cnt, phase: wb || fill};
    exp_q.push_back(r);
    while (!req_ready) begin
      scramble(hold);
      @(negedge clk);
      n++;
      if (n > 300) begin
        $display("FAIL accept_timeout: req_ready stuck low for %0d cycles", n);
        $fatal(1);
      end
    end
    req_valid = 1'b1; req_wb = wb; req_fill = fill;
    req_wb_addr = wa; req_wb_data = wd; req_fill_addr = fa;
    @(negedge clk);
    scramble(hold);
  endtask

  initial begin : stimulus
    int n;
    rst = 1'b1;
    req_valid = 1'b0; req_wb = 1'b0; req_fill = 1'b0;
    req_wb_addr = '0; req_fill_addr = '0; req_wb_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_mem_read", 128'(mem_read), 128'(0));
    chk("rst_mem_write", 128'(mem_write), 128'(0));
    chk("rst_mem_addr", 128'(mem_addr), 128'(0));
    chk("rst_mem_wdata", mem_wdata, 128'(0));
    chk("rst_resp", {resp_data[125:0], resp_valid, resp_err}, 128'(0));
    chk("rst_fill_cnt", 128'(fill_cnt), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_ready", 128'(req_ready), 128'(1));
    rst = 1'b0;

    // Directed: fill only, write-back + fill, write-back only, empty transaction.
    issue(0, 1, '0, '0, 28'h0000010, 0, 10, 128'hDEADBEEF_00000001_00000002_00000003, 0);
    issue(1, 1, 28'h20, {4{32'h11111111}}, 28'h30, 3, 5, rnd128(), 0);
    issue(1, 0, 28'h44, rnd128(), 28'h55, 4, 0, '0, 0);
    issue(0, 0, 28'h66, rnd128(), 28'h77, 0, 0, '0, 0);

    // Back-to-back with req_valid held high and fields churning while busy.
    for (int i = 0; i < 4; i++)
      issue(1'($urandom_range(1)), 1, 28'($urandom()), rnd128(), 28'($urandom()),
            $urandom_range(1, 5), $urandom_range(1, 5), rnd128(), 1);

    // Timeout boundaries.
    issue(0, 1, '0, '0, 28'h100, 0, NEVER, rnd128(), 0);
    issue(0, 1, '0, '0, 28'h101, 0, TMO, rnd128(), 0);
    issue(0, 1, '0, '0, 28'h102, 0, TMO + 1, rnd128(), 0);
    issue(1, 1, 28'h103, rnd128(), 28'h104, NEVER, 2, rnd128(), 0);
    issue(1, 1, 28'h105, rnd128(), 28'h106, TMO, NEVER, rnd128(), 0);

    // Reset in the middle of a refill.
    issue(0, 1, '0, '0, 28'h200, 0, NEVER, rnd128(), 0);
    n = 0;
    while (!mem_read && n < 100) begin @(negedge clk); n++; end
    chk("rd_started", 128'(mem_read), 128'(1));
    repeat (3) @(negedge clk);
    rst = 1'b1;
    req_valid = 1'b0;
    void'(exp_q.pop_back());
    m_data = '0;
    m_cnt  = '0;
    @(negedge clk);
    rst = 1'b0;
    #3;
    chk("abort_mem_read", 128'(mem_read), 128'(0));
    chk("abort_busy", 128'(busy), 128'(0));
    chk("abort_fill_cnt", 128'(fill_cnt), 128'(0));
    chk("abort_resp_valid", 128'(resp_valid), 128'(0));
    @(negedge clk);
    issue(1, 1, 28'h300, rnd128(), 28'h301, 2, 3, rnd128(), 0);

    // Randomized traffic.
    for (int i = 0; i < 40; i++)
      issue(1'($urandom_range(1)), 1'($urandom_range(1)), 28'($urandom()), rnd128(),
            28'($urandom()), $urandom_range(1, TMO + 2), $urandom_range(1, TMO + 2),
            rnd128(), 1'($urandom_range(1)));

    req_valid = 1'b0;
    n = 0;
    while ((exp_q.size() != 0 || op_q.size() != 0) && n < 200) begin @(negedge clk); n++; end
    repeat (4) @(negedge clk);
    chk("drain_resp", 128'(exp_q.size()), 128'(0));
    chk("drain_ops", 128'(op_q.size()), 128'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

endmodule

// File: doc/mem_line_master.md
Name: mem_line_master

Overview:
- Initiator side of the 128-bit line-transfer handshake (mem_read/mem_write/mem_addr[31:4]/mem_wdata/mem_rdata/mem_ready) served by slow_memory.
- Sits between a cache controller (I or D) and the slow memory port of CHIP.
- Accepts one miss transaction at a time: optional dirty-line write-back, then optional line refill.
- Returns refill data to the cache with a one-cycle response pulse.

Parameters:
- ADDR_W, 28, line address width (byte address bits 31:4)
- LINE_W, 128, line data width
- TIMEOUT, 0, max cycles a memory request may stay unanswered; 0 disables the timeout

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous active-high reset
- req_valid  in  1  cache presents a transaction
- req_ready  out  1  block can accept a transaction (combinational: state==IDLE)
- req_wb  in  1  write-back phase required
- req_wb_addr  in  ADDR_W  write-back line address
- req_wb_data  in  LINE_W  dirty line data
- req_fill  in  1  refill phase required
- req_fill_addr  in  ADDR_W  refill line address
- resp_valid  out  1  one-cycle completion pulse
- resp_data  out  LINE_W  refill data, held until the next refill completes
- resp_err  out  1  valid with resp_valid; 1 = a phase timed out
- busy  out  1  high in every state except IDLE (drives cache stall)
- fill_cnt  out  16  completed refills, saturating at 16'hFFFF
- mem_read  out  1  read request to memory
- mem_write  out  1  write request to memory
- mem_addr  out  ADDR_W  line address to memory
- mem_wdata  out  LINE_W  write data to memory
- mem_rdata  in  LINE_W  read data from memory
- mem_ready  in  1  memory completion, one-cycle pulse

Behaviour:
- Reset: state IDLE. Outputs reset to mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0, resp_valid=0, resp_data=0, resp_err=0, fill_cnt=0, busy=0.
- Reset mid-transaction aborts it on the same edge. No response is produced and the memory request drops the next cycle.
- All outputs except req_ready are registered.
- Handshake: a transaction is accepted on an edge where req_valid && req_ready. All req_* fields are latched on that edge and their later changes are ignored.
- State machine: IDLE, WB_REQ, GAP, RD_REQ, RESP.
- IDLE, on accept:
  - req_wb=1: go to WB_REQ.
  - req_wb=0, req_fill=1: go to RD_REQ.
  - both 0: go to RESP.
- WB_REQ:
  - mem_write=1, mem_addr=wb_addr, mem_wdata=wb_data, all stable until mem_ready is sampled high.
  - On mem_ready: mem_write=0 next cycle. Go to GAP if fill is pending, else RESP.
- GAP: exactly one cycle with mem_read=mem_write=0, then RD_REQ. Consecutive requests are never back-to-back.
- RD_REQ:
  - mem_read=1, mem_addr=fill_addr until mem_ready is sampled high.
  - On that edge: capture mem_rdata into resp_data, increment fill_cnt (saturating), go to RESP.
- RESP: resp_valid=1 for exactly this cycle, then IDLE. req_ready is 0 in RESP, so the earliest next accept is the cycle after RESP.
- Memory request rules:
  - mem_read and mem_write are never both high.
  - mem_ready sampled in IDLE, GAP or RESP is ignored.
- Latency: accept at edge E0 puts the request on the bus in the cycle after E0. If mem_ready is sampled at edge Er, resp_valid is high in the cycle after Er (single phase).
- Timeout (TIMEOUT>0):
  - A per-phase counter clears on entering WB_REQ/RD_REQ and increments each cycle without mem_ready.
  - When it reaches TIMEOUT: drop the request, go to RESP with resp_err=1. The fill phase is skipped, resp_data is unchanged and fill_cnt is not incremented.
  - mem_ready on the same edge as the count reaching TIMEOUT wins (normal completion).
- resp_err is cleared at the start of every accepted transaction.

Test Plan:
1. Fill only: fill_addr=28'h0000010; memory returns 128'hDEADBEEF_00000001_00000002_00000003 after 10 cycles.
   -> mem_read high 10 cycles, mem_addr=0x0000010, mem_write=0.
   -> resp_valid one cycle later with that data, fill_cnt=1, resp_err=0.
2. Write-back + fill: wb_addr=0x20, wb_data=128'h1111..., fill_addr=0x30.
   -> mem_write phase with addr 0x20 and data 0x1111...
   -> exactly one idle cycle, then mem_read with addr 0x30.
   -> single resp_valid; fill_cnt increments once.
3. Write-back only (req_fill=0).
   -> resp_valid after write mem_ready; resp_data unchanged; fill_cnt unchanged.
4. Stimulus: req_fields change while busy; req_valid held high continuously; spurious mem_ready in IDLE.
   -> latched values used; second transaction accepted only the cycle after RESP; spurious mem_ready ignored.
5. TIMEOUT=8, memory never answers.
   -> mem_read drops after 8 cycles, resp_valid with resp_err=1, fill_cnt unchanged.
   -> Repeat with mem_ready on the 8th cycle -> resp_err=0, data captured.
6. Assert rst during RD_REQ.
   -> mem_read=0, busy=0, fill_cnt=0 next cycle, no resp_valid.
   -> New transaction after reset completes normally.
